// File: rtl/vc_core_nic.sv
// Network interface between a core and one router port: credit-based virtual-channel
// injection with round-robin VC allocation, plus a show-ahead ejection buffer that returns credits.
module vc_core_nic #(
  parameter  int FLIT_W    = 32,
  parameter  int NUM_VC    = 4,
  parameter  int BUF_DEPTH = 4,
  parameter  int INJ_DEPTH = 8,
  localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] inj_flit,
  input  logic              inj_valid,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic [VC_W-1:0]   out_vc,
  input  logic              credit_in_valid,
  input  logic [VC_W-1:0]   credit_in_vc,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  input  logic [VC_W-1:0]   in_vc,
  output logic [FLIT_W-1:0] ej_flit,
  output logic [VC_W-1:0]   ej_vc,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic              credit_out_valid,
  output logic [VC_W-1:0]   credit_out_vc,
  output logic              err
);

  localparam int IP_W     = $clog2(INJ_DEPTH);
  localparam int IC_W     = $clog2(INJ_DEPTH + 1);
  localparam int EJ_DEPTH = NUM_VC * BUF_DEPTH;
  localparam int EP_W     = (EJ_DEPTH > 1) ? $clog2(EJ_DEPTH) : 1;
  localparam int EC_W     = $clog2(EJ_DEPTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic [1:0] {FT_HEAD = 2'b00, FT_BODY = 2'b01, FT_TAIL = 2'b10, FT_HEADTAIL = 2'b11} ftype_t;

  // ---------------- injection FIFO ----------------
  logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
  logic [IP_W-1:0]   inj_wp, inj_rp;
  logic [IC_W-1:0]   inj_cnt;
  logic              inj_full, inj_empty, inj_push, inj_pop;
  logic [FLIT_W-1:0] inj_head;

  assign inj_full  = (inj_cnt == IC_W'(INJ_DEPTH));
  assign inj_empty = (inj_cnt == '0);
  assign inj_ready = !inj_full;
  assign inj_push  = inj_valid && !inj_full;
  assign inj_head  = inj_mem[inj_rp];

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wp] <= inj_flit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_wp  <= '0;
      inj_rp  <= '0;
      inj_cnt <= '0;
    end else begin
      if (inj_push) inj_wp <= inj_wp + IP_W'(1);
      if (inj_pop)  inj_rp <= inj_rp + IP_W'(1);
      if (inj_push && !inj_pop)      inj_cnt <= inj_cnt + IC_W'(1);
      else if (!inj_push && inj_pop) inj_cnt <= inj_cnt - IC_W'(1);
    end
  end

  // ---------------- credits and VC allocation ----------------
  logic [CNT_W-1:0] credit [NUM_VC];
  state_t           state, state_nxt;
  logic [VC_W-1:0]  cur_vc, cur_nxt, rr_ptr, rr_nxt;
  logic [VC_W-1:0]  pick, cand, send_vc;
  logic             found, send, proto_err, cred_ovf;
  ftype_t           head_type;
  logic             head_is_head;

  assign head_type    = ftype_t'(inj_head[FLIT_W-1 -: 2]);
  assign head_is_head = (head_type == FT_HEAD) || (head_type == FT_HEADTAIL);

  // Only IDLE consults the search, so every VC at full credit is a candidate.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      cand = VC_W'((32'(rr_ptr) + i) % NUM_VC);
      if (!found && credit[cand] == CNT_W'(BUF_DEPTH)) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_vc;
    rr_nxt    = rr_ptr;
    inj_pop   = 1'b0;
    send      = 1'b0;
    send_vc   = cur_vc;
    proto_err = 1'b0;
    case (state)
      IDLE: begin
        if (!inj_empty) begin
          if (head_is_head) begin
            if (found) begin
              inj_pop = 1'b1;
              send    = 1'b1;
              send_vc = pick;
              rr_nxt  = VC_W'((32'(pick) + 1) % NUM_VC);
              if (head_type == FT_HEAD) begin
                state_nxt = ACTIVE;
                cur_nxt   = pick;
              end
            end
          end else begin
            inj_pop   = 1'b1;
            proto_err = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!inj_empty) begin
          if (head_is_head) begin
            inj_pop   = 1'b1;
            proto_err = 1'b1;
          end else if (credit[cur_vc] != '0) begin
            inj_pop = 1'b1;
            send    = 1'b1;
            send_vc = cur_vc;
            if (head_type == FT_TAIL) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cred_ovf = credit_in_valid && (credit[credit_in_vc] == CNT_W'(BUF_DEPTH)) &&
                    !(send && send_vc == credit_in_vc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cur_vc <= '0;
      rr_ptr <= '0;
      for (int unsigned v = 0; v < NUM_VC; v++) credit[v] <= CNT_W'(BUF_DEPTH);
    end else begin
      state  <= state_nxt;
      cur_vc <= cur_nxt;
      rr_ptr <= rr_nxt;
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (credit_in_valid && credit_in_vc == VC_W'(v) && !(send && send_vc == VC_W'(v))) begin
          if (credit[v] != CNT_W'(BUF_DEPTH)) credit[v] <= credit[v] + CNT_W'(1);
        end else if (send && send_vc == VC_W'(v) && !(credit_in_valid && credit_in_vc == VC_W'(v))) begin
          credit[v] <= credit[v] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_vc    <= '0;
    end else begin
      out_valid <= send;
      if (send) begin
        out_flit <= inj_head;
        out_vc   <= send_vc;
      end
    end
  end

  // ---------------- ejection FIFO ----------------
  logic [VC_W+FLIT_W-1:0] ej_mem [EJ_DEPTH];
  logic [EP_W-1:0]        ej_wp, ej_rp;
  logic [EC_W-1:0]        ej_cnt;
  logic                   ej_full, ej_push, ej_pop, ej_ovf;

  assign ej_full  = (ej_cnt == EC_W'(EJ_DEPTH));
  assign ej_valid = (ej_cnt != '0);
  assign ej_pop   = ej_valid && ej_ready;
  assign ej_push  = in_valid && (!ej_full || ej_pop);
  assign ej_ovf   = in_valid && ej_full && !ej_pop;
  assign {ej_vc, ej_flit} = ej_mem[ej_rp];

  always_ff @(posedge clk) begin
    if (ej_push) ej_mem[ej_wp] <= {in_vc, in_flit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ej_wp            <= '0;
      ej_rp            <= '0;
      ej_cnt           <= '0;
      credit_out_valid <= 1'b0;
      credit_out_vc    <= '0;
      err              <= 1'b0;
    end else begin
      if (ej_push) ej_wp <= (ej_wp == EP_W'(EJ_DEPTH - 1)) ? '0 : ej_wp + EP_W'(1);
      if (ej_pop)  ej_rp <= (ej_rp == EP_W'(EJ_DEPTH - 1)) ? '0 : ej_rp + EP_W'(1);
      if (ej_push && !ej_pop)      ej_cnt <= ej_cnt + EC_W'(1);
      else if (!ej_push && ej_pop) ej_cnt <= ej_cnt - EC_W'(1);
      credit_out_valid <= ej_pop;
      if (ej_pop) credit_out_vc <= ej_vc;
      if (proto_err || cred_ovf || ej_ovf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_core_nic.sv
// Directed bench for vc_core_nic: VC allocation, credit flow, protocol errors and ejection credits.
module tb_vc_core_nic;

  logic        clk;
  logic        reset;
  logic [31:0] inj_flit;
  logic        inj_valid;
  logic        inj_ready;
  logic [31:0] out_flit;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic        credit_in_valid;
  logic [1:0]  credit_in_vc;
  logic [31:0] in_flit;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [31:0] ej_flit;
  logic [1:0]  ej_vc;
  logic        ej_valid;
  logic        ej_ready;
  logic        credit_out_valid;
  logic [1:0]  credit_out_vc;
  logic        err;

  int checks = 0;
  int errors = 0;

  vc_core_nic #(.FLIT_W(32), .NUM_VC(4), .BUF_DEPTH(4), .INJ_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_vc(out_vc),
    .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
    .in_flit(in_flit), .in_valid(in_valid), .in_vc(in_vc),
    .ej_flit(ej_flit), .ej_vc(ej_vc), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .credit_out_valid(credit_out_valid), .credit_out_vc(credit_out_vc),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    inj_valid = 1'b0;
    in_valid = 1'b0;
    credit_in_valid = 1'b0;
    ej_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  logic [31:0] pkt [6];
  int sent;

  initial begin
    inj_flit = '0; in_flit = '0; in_vc = '0; credit_in_vc = '0;
    do_reset();

    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit", 64'(out_flit), 64'd0);
    chk("rst_out_vc", 64'(out_vc), 64'd0);
    chk("rst_cred_out_valid", 64'(credit_out_valid), 64'd0);
    chk("rst_cred_out_vc", 64'(credit_out_vc), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_inj_ready", 64'(inj_ready), 64'd1);
    chk("rst_ej_valid", 64'(ej_valid), 64'd0);
    for (int v = 0; v < 4; v++) chk("rst_credit", 64'(dut.credit[v]), 64'd4);

    // HEADTAIL latency and round robin
    inj_flit = mk(2'b11, 30'h11); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk("ht1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    chk("ht1_valid", 64'(out_valid), 64'd1);
    chk("ht1_vc", 64'(out_vc), 64'd0);
    chk("ht1_flit", 64'(out_flit), 64'(mk(2'b11, 30'h11)));
    inj_flit = mk(2'b11, 30'h22); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    chk("ht2_gap_valid", 64'(out_valid), 64'd0);
    tick();
    chk("ht2_valid", 64'(out_valid), 64'd1);
    chk("ht2_vc", 64'(out_vc), 64'd1);
    chk("ht2_flit", 64'(out_flit), 64'(mk(2'b11, 30'h22)));
    chk("ht_err", 64'(err), 64'd0);

    // 6-flit packet, credits exhaust after four flits
    do_reset();
    pkt[0] = mk(2'b00, 30'h100);
    pkt[1] = mk(2'b01, 30'h101);
    pkt[2] = mk(2'b01, 30'h102);
    pkt[3] = mk(2'b01, 30'h103);
    pkt[4] = mk(2'b01, 30'h104);
    pkt[5] = mk(2'b10, 30'h105);
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 6) begin
        inj_flit = pkt[c]; inj_valid = 1'b1;
      end else begin
        inj_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        if (sent < 6) chk("pkt_flit", 64'(out_flit), 64'(pkt[sent]));
        chk("pkt_vc", 64'(out_vc), 64'd0);
        sent++;
      end
    end
    inj_valid = 1'b0;
    chk("pkt_sent_before_stall", 64'(sent), 64'd4);
    chk("pkt_credit0_zero", 64'(dut.credit[0]), 64'd0);
    credit_in_valid = 1'b1; credit_in_vc = 2'd0;
    tick();
    credit_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) begin
        if (sent < 6) chk("pkt_flit_after_credit", 64'(out_flit), 64'(pkt[sent]));
        sent++;
      end
    end
    chk("pkt_sent_after_credit", 64'(sent), 64'd5);
    chk("pkt_credit0_after", 64'(dut.credit[0]), 64'd0);

    // credit return on the same edge as a send leaves the counter unchanged
    credit_in_valid = 1'b1; credit_in_vc = 2'd0;
    tick();
    chk("simul_credit_pre", 64'(dut.credit[0]), 64'd1);
    tick();
    credit_in_valid = 1'b0;
    chk("simul_tail_valid", 64'(out_valid), 64'd1);
    chk("simul_tail_flit", 64'(out_flit), 64'(pkt[5]));
    chk("simul_credit_unchanged", 64'(dut.credit[0]), 64'd1);
    chk("simul_err", 64'(err), 64'd0);

    // credit overflow on an idle VC
    credit_in_valid = 1'b1; credit_in_vc = 2'd1;
    tick();
    credit_in_valid = 1'b0;
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_credit1", 64'(dut.credit[1]), 64'd4);

    // BODY at the head in IDLE is dropped
    do_reset();
    chk("body_rst_err", 64'(err), 64'd0);
    inj_flit = mk(2'b01, 30'h200); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("body_no_send", 64'(out_valid), 64'd0);
    chk("body_err", 64'(err), 64'd1);
    tick();
    chk("body_no_send_later", 64'(out_valid), 64'd0);
    chk("body_popped", 64'(dut.inj_cnt), 64'd0);

    // reset in the middle of a packet
    do_reset();
    inj_flit = mk(2'b00, 30'h300); inj_valid = 1'b1;
    tick();
    inj_flit = mk(2'b01, 30'h301);
    tick();
    inj_flit = mk(2'b01, 30'h302);
    tick();
    inj_valid = 1'b0;
    chk("mid_active_sent", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int v = 0; v < 4; v++) chk("mid_credit", 64'(dut.credit[v]), 64'd4);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_err", 64'(err), 64'd0);
    chk("mid_inj_ready", 64'(inj_ready), 64'd1);
    chk("mid_ej_valid", 64'(ej_valid), 64'd0);
    inj_flit = mk(2'b11, 30'h310); inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    tick();
    chk("mid_ht_valid", 64'(out_valid), 64'd1);
    chk("mid_ht_vc", 64'(out_vc), 64'd0);
    chk("mid_ht_flit", 64'(out_flit), 64'(mk(2'b11, 30'h310)));
    tick(); tick(); tick();
    chk("mid_no_leftover", 64'(out_valid), 64'd0);
    chk("mid_no_err", 64'(err), 64'd0);

    // ejection: fill 16, overflow on 17th, drain with credits
    do_reset();
    for (int k = 0; k < 16; k++) begin
      in_flit = 32'hA500_0000 + 32'(k); in_vc = 2'(k % 4); in_valid = 1'b1;
      tick();
    end
    chk("ej_full_valid", 64'(ej_valid), 64'd1);
    chk("ej_full_err", 64'(err), 64'd0);
    chk("ej_head_flit", 64'(ej_flit), 64'h0000_0000_A500_0000);
    in_flit = 32'hDEAD_0000; in_vc = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("ej_ovf_err", 64'(err), 64'd1);
    chk("ej_ovf_no_credit", 64'(credit_out_valid), 64'd0);
    ej_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("ej_flit", 64'(ej_flit), 64'(32'hA500_0000 + 32'(k)));
      chk("ej_vc", 64'(ej_vc), 64'(k % 4));
      tick();
      chk("ej_cred_valid", 64'(credit_out_valid), 64'd1);
      chk("ej_cred_vc", 64'(credit_out_vc), 64'(k % 4));
    end
    chk("ej_empty", 64'(ej_valid), 64'd0);
    tick();
    chk("ej_cred_idle", 64'(credit_out_valid), 64'd0);
    ej_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_core_nic.md
VC_CORE_NIC -- requirements
Module: vc_core_nic

Interface
REQ-001 Parameter FLIT_W, 32, flit width in bits; bits [FLIT_W-1:FLIT_W-2] carry the flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
REQ-002 Parameter NUM_VC, 4, number of virtual channels on the router port; VC_W = max(1, clog2(NUM_VC)).
REQ-003 Parameter BUF_DEPTH, 4, downstream router buffer depth per VC, which is also the initial credit count; CNT_W = clog2(BUF_DEPTH+1).
REQ-004 Parameter INJ_DEPTH, 8, injection FIFO depth; power of two, at least 2.
REQ-005 The interface SHALL use one clock and a synchronous, active-high reset. The ports are:
 - clk  in  1  clock, all state updates on its rising edge
 - reset  in  1  synchronous active-high reset
 - inj_flit  in  FLIT_W  flit from the core
 - inj_valid  in  1  inj_flit is valid
 - inj_ready  out  1  injection FIFO not full
 - out_flit  out  FLIT_W  flit sent to the router
 - out_valid  out  1  out_flit is valid this cycle
 - out_vc  out  VC_W  VC of out_flit
 - credit_in_valid  in  1  router returned one credit
 - credit_in_vc  in  VC_W  VC of the returned credit
 - in_flit  in  FLIT_W  flit ejected by the router
 - in_valid  in  1  in_flit is valid
 - in_vc  in  VC_W  VC of in_flit
 - ej_flit  out  FLIT_W  flit to the core
 - ej_vc  out  VC_W  VC tag of ej_flit
 - ej_valid  out  1  ejection FIFO not empty
 - ej_ready  in  1  core accepts ej_flit
 - credit_out_valid  out  1  return one credit to the router
 - credit_out_vc  out  VC_W  VC of that credit
 - err  out  1  sticky protocol error flag

Function
REQ-006 The injection FIFO SHALL write on inj_valid&&inj_ready; inj_ready = !full; writes while full are ignored.
REQ-007 Per-VC credit counters SHALL hold values 0..BUF_DEPTH: decrement by 1 on each flit sent on that VC, increment by 1 on credit_in_valid for that VC, and stay unchanged when both occur in the same cycle.
REQ-008 The injection FSM SHALL have two states, IDLE and ACTIVE, and hold registers cur_vc and rr_ptr.
REQ-009 A VC is eligible in IDLE when its credit counter equals BUF_DEPTH and it is not cur_vc in ACTIVE.
REQ-010 IDLE: when the FIFO head is HEAD or HEADTAIL and some VC is eligible, the FSM SHALL pick the first eligible VC searching rr_ptr, rr_ptr+1, ... (mod NUM_VC), send the head in the same cycle, and set rr_ptr = chosen+1 mod NUM_VC.
REQ-011 After a HEAD send the FSM SHALL go to ACTIVE with cur_vc = the chosen VC; after a HEADTAIL send it SHALL stay in IDLE.
REQ-012 ACTIVE: when the FIFO is non-empty and credit[cur_vc] > 0, the FSM SHALL pop and send one flit per cycle on cur_vc; a TAIL send returns the FSM to IDLE.
REQ-013 In IDLE, a FIFO head of type BODY or TAIL SHALL be popped, dropped without being sent, and set err; in ACTIVE, a HEAD or HEADTAIL is likewise dropped with err set and the FSM stays ACTIVE.
REQ-014 Sends are registered: a send decided in cycle t drives out_valid=1 with out_flit and out_vc in cycle t+1, and out_valid=0 in any cycle with no send; minimum latency from inj write to out_valid is 2 cycles.
REQ-015 Credit overflow (credit_in_valid on a VC at BUF_DEPTH with no same-cycle send) SHALL leave the counter at BUF_DEPTH and set err.
REQ-016 The ejection FIFO SHALL be show-ahead, depth NUM_VC*BUF_DEPTH, storing {in_vc, in_flit}; writes occur on in_valid.
REQ-017 in_valid while the ejection FIFO is full and not popping in the same cycle SHALL drop the flit and set err; a simultaneous push and pop when full is legal.
REQ-018 ej_valid = !empty; a pop occurs on ej_valid&&ej_ready, and ej_flit/ej_vc reflect the FIFO head.
REQ-019 A pop in cycle t SHALL drive credit_out_valid=1 and credit_out_vc = the popped VC in cycle t+1; credit_out_valid is otherwise 0.
REQ-020 The FIFO pointers SHALL wrap modulo depth, with full/empty tracked by occupancy counters.

Reset
REQ-021 On reset the block SHALL set: FSM = IDLE, cur_vc=0, rr_ptr=0, all credit counters = BUF_DEPTH, both FIFOs empty, out_valid=0, out_flit=0, out_vc=0, credit_out_valid=0, credit_out_vc=0, err=0, inj_ready=1, ej_valid=0.
REQ-022 Reset asserted mid-packet SHALL discard all buffered flits and the in-flight packet, with no partial completion.

Verification
REQ-023 Reset, then a HEADTAIL inj write at cycle 0 -> out_valid=1 with out_vc=0 at cycle 2; a second HEADTAIL -> out_vc=1 (round robin).
REQ-024 A 6-flit packet (H,B,B,B,B,T) with BUF_DEPTH=4 and no credits returned -> 4 flits sent on VC0, then stall; one credit_in on VC0 -> exactly one more flit sent.
REQ-025 Simultaneous credit_in and send on the same VC -> counter unchanged; credit_in on a VC at 4 -> err=1 and counter stays 4.
REQ-026 16 in_valid flits with ej_ready=0 -> all stored; a 17th -> dropped and err=1; then ej_ready=1 -> 16 credit_out pulses, each one cycle after its pop, carrying the matching VC.
REQ-027 BODY flit at the FIFO head in IDLE -> popped, no out_valid, err=1; reset mid-packet -> credits=4, FSM=IDLE, FIFOs empty.
